phase_cmd_ctrl: RTL and testbench
=================================

// Module: phase_cmd_ctrl
// PURPOSE
//  Byte-stream command controller for the transducer phase-offset bank. Sits between the UART
//  rx/tx streams and the parallel clock generators: parses 3-byte frames, writes a shadow offset
//  bank, commits shadow->active with a one-cycle active-low reload strobe, and returns ACK/NAK/readback.
// PARAMETERS
//  OUTPUTS    16  number of clock-generator channels (1..32)
//  OFFSET_W   24  width of each offset word driven to a generator
//  INIT_STEP  10  reset offset of channel i = i*INIT_STEP (both banks)
// PORTS
//  clk          in   1                 system clock; sole clock domain
//  rst          in   1                 synchronous, active-high reset
//  rx_data      in   8                 received byte
//  rx_valid     in   1                 rx_data valid
//  rx_ready     out  1                 byte accepted when rx_valid&rx_ready at posedge
//  tx_data      out  8                 response byte
//  tx_valid     out  1                 tx_data valid; held with tx_data stable until tx_ready
//  tx_ready     in   1                 UART transmitter accepts byte
//  offsets      out  OUTPUTS*OFFSET_W  active bank, channel j at [OFFSET_W*j +: OFFSET_W]
//  reload_n     out  1                 low for exactly one cycle per commit; generators reload
//  err_count    out  8                 saturating count of framing errors
// BEHAVIOUR
//  Frame: B0={1,op[1:0],ch[4:0]}, B1={0,d[13:7]}, B2={0,d[6:0]}; bit7 marks frame start.
//  Ops: 0 SET: shadow[ch]<=zero-extended d. 1 COMMIT: active<=shadow (all ch), reload_n=0 one cycle.
//    2 READ: reply 3 bytes of shadow[ch][13:0] in frame format (B0 echoed). 3 PING: reply B0 only.
//  Every frame (ops 0/1/2/3) is fully 3 bytes; d ignored for COMMIT/PING.
//  FSM: IDLE -> GOT1 (B0) -> GOT2 (B1) -> EXEC (B2) -> RESP -> IDLE.
//   - rx_ready=1 only in IDLE/GOT1/GOT2; 0 in EXEC/RESP (no byte lost, upstream back-pressured).
//   - EXEC lasts 1 cycle: performs write/commit, loads response. RESP drives tx until last byte taken.
//   - Response for SET/COMMIT = B0 echo (ACK); ch>=OUTPUTS on SET/READ -> single 0xFF (NAK), no write.
//  Resync: byte with bit7=1 in GOT1/GOT2 restarts frame as new B0, err_count+1.
//   Byte with bit7=0 in IDLE: discarded, err_count+1. err_count saturates at 255.
//  Latency: accept B2 at cycle N -> EXEC at N+1 -> tx_valid=1 and (COMMIT) offsets updated,
//   reload_n=0 at N+2; reload_n=1 again at N+3. offsets change only in the reload_n=0 cycle.
//  Back-to-back COMMITs give separate one-cycle strobes, never merged.
//  Reset (any cycle, incl. mid-frame/mid-response): state=IDLE, rx_ready=0, tx_valid=0,
//   tx_data=0, reload_n=0 while rst, err_count=0, both banks = i*INIT_STEP. First cycle after
//   rst: reload_n=1, rx_ready=1. Pending tx byte abandoned.
//  Widths: d 14 bits zero-extended to OFFSET_W; if OFFSET_W<14, truncated to LSBs.
// STRUCTURE
//  Shared header fmq_defs.vh: opcode constants OP_SET/OP_COMMIT/OP_READ/OP_PING, NAK=8'hFF,
//   frame bit positions. Shared with host software spec.
//  One sub-module: resp_serializer (up to 3-byte buffer + count, valid/ready driver to tx).
//  Parser FSM, banks and reload strobe live in phase_cmd_ctrl.
// TESTING
//  1 Reset then idle: offsets ch j = 10*j, reload_n 0 during rst, 1 after; err_count=0.
//  2 SET ch3=0x1234 (0x83,0x24,0x34) then COMMIT (0xA0,0,0): ACK 0x83 then 0xA0; offsets ch3
//    stays 30 until commit, =0x1234 in reload_n=0 cycle; exactly one low cycle.
//  3 READ ch3 after SET 0x1234 pre-commit -> tx 0xC3,0x24,0x34; active bank unchanged.
//  4 SET ch=20 (OUTPUTS=16) -> tx 0xFF only, no bank change; PING 0xE5,0,0 -> tx 0xE5.
//  5 Framing: 0x05 in IDLE, then 0x83,0x80,0x01,0x02 -> err_count=2, frame 0x80 SET ch0=0x0082.
//  6 tx_ready held low 20 cycles during READ reply: tx_data stable, rx_ready=0; rst mid-reply
//    -> tx_valid=0 next cycle, banks = reset values.

Source files
------------

// File: rtl/phase_cmd_ctrl_pkg.sv
// Shared frame layout, opcodes and parser states for the phase-offset command controller.
// The opcode and NAK values are the same ones the host software uses.
package phase_cmd_ctrl_pkg;

  typedef enum logic [1:0] {
    OP_SET    = 2'd0,
    OP_COMMIT = 2'd1,
    OP_READ   = 2'd2,
    OP_PING   = 2'd3
  } op_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_GOT1,
    S_GOT2,
    S_EXEC,
    S_RESP
  } state_e;

  // First byte of a frame: start flag, opcode, channel.
  typedef struct packed {
    logic       start;
    op_e        op;
    logic [4:0] ch;
  } hdr_t;

  localparam logic [7:0] NAK             = 8'hFF;
  localparam int         FRAME_START_BIT = 7;
  localparam int         DATA_W          = 14;
  localparam int         RESP_MAX        = 3;

  // Payload bytes always carry a clear start bit.
  function automatic logic [7:0] data_byte(input logic [6:0] v);
    return {1'b0, v};
  endfunction

endpackage

// File: rtl/phase_cmd_ctrl_if.sv
// Byte-stream link between the UART rx/tx and the command controller.
// master = host/UART side, slave = controller side.
interface phase_cmd_ctrl_if;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;

  modport master (
    output rx_data, rx_valid, tx_ready,
    input  rx_ready, tx_data, tx_valid
  );

  modport slave (
    input  rx_data, rx_valid, tx_ready,
    output rx_ready, tx_data, tx_valid
  );
endinterface

// File: rtl/phase_cmd_ctrl_resp_serializer.sv
// Holds a response of up to three bytes and plays it out on a valid/ready stream,
// keeping tx_data stable until each byte is taken.
module resp_serializer
  import phase_cmd_ctrl_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     load,
  input  logic [RESP_MAX-1:0][7:0] load_bytes,
  input  logic [1:0]               load_len,
  output logic [7:0]               tx_data,
  output logic                     tx_valid,
  input  logic                     tx_ready,
  output logic                     done
);

  logic [RESP_MAX-1:0][7:0] buf_q;
  logic [1:0]               cnt_q;

  // NOTE: state registers use non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      buf_q <= '0;
      cnt_q <= '0;
    end else if (load) begin
      buf_q <= load_bytes;
      cnt_q <= load_len;
    end else if (cnt_q != 2'd0 && tx_ready) begin
      buf_q <= {8'h00, buf_q[2], buf_q[1]};
      cnt_q <= cnt_q - 2'd1;
    end
  end

  // A pending byte is abandoned the moment reset is seen.
  assign tx_valid = (cnt_q != 2'd0) && !rst;
  assign tx_data  = rst ? 8'h00 : buf_q[0];
  assign done     = (cnt_q == 2'd1) && tx_ready;

endmodule

// File: rtl/phase_cmd_ctrl.sv
// Parses 3-byte command frames, maintains shadow/active phase-offset banks and
// issues a one-cycle active-low reload strobe whenever the shadow bank is committed.
module phase_cmd_ctrl
  import phase_cmd_ctrl_pkg::*;
#(
  parameter int OUTPUTS   = 16,
  parameter int OFFSET_W  = 24,
  parameter int INIT_STEP = 10
) (
  input  logic                         clk,
  input  logic                         rst,
  phase_cmd_ctrl_if.slave              bus,
  output logic [OUTPUTS*OFFSET_W-1:0]  offsets,
  output logic                         reload_n,
  output logic [7:0]                   err_count
);

  localparam int CH_W = (OUTPUTS > 1) ? $clog2(OUTPUTS) : 1;

  state_e                   state_q, state_d;
  hdr_t                     b0_q;
  logic [6:0]               b1_q, b2_q;
  logic [OFFSET_W-1:0]      shadow_q [OUTPUTS];
  logic [OFFSET_W-1:0]      active_q [OUTPUTS];
  logic                     reload_q;
  logic                     is_start, rx_fire, bad_byte, exec, ch_bad, ser_done;
  logic [CH_W-1:0]          ch_idx;
  logic [DATA_W-1:0]        d_word, rd_word;
  logic [RESP_MAX-1:0][7:0] resp_bytes;
  logic [1:0]               resp_len;

  assign bus.rx_ready = !rst && (state_q inside {S_IDLE, S_GOT1, S_GOT2});
  assign rx_fire      = bus.rx_valid && bus.rx_ready;
  assign is_start     = bus.rx_data[FRAME_START_BIT];
  // Data byte with no frame open, or a start byte that cuts a frame short.
  assign bad_byte     = (state_q == S_IDLE) ? !is_start : is_start;

  assign exec    = (state_q == S_EXEC);
  assign ch_idx  = b0_q.ch[CH_W-1:0];
  assign ch_bad  = (b0_q.op inside {OP_SET, OP_READ}) && (int'(b0_q.ch) >= OUTPUTS);
  assign d_word  = {b1_q, b2_q};
  assign rd_word = DATA_W'(shadow_q[ch_idx]);

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (rx_fire && is_start) state_d = S_GOT1;
      S_GOT1:  if (rx_fire) state_d = is_start ? S_GOT1 : S_GOT2;
      S_GOT2:  if (rx_fire) state_d = is_start ? S_GOT1 : S_EXEC;
      S_EXEC:  state_d = S_RESP;
      S_RESP:  if (ser_done) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    resp_bytes = '0;
    resp_len   = 2'd1;
    if (ch_bad) begin
      resp_bytes[0] = NAK;
    end else begin
      resp_bytes[0] = b0_q;
      if (b0_q.op == OP_READ) begin
        resp_bytes[1] = data_byte(rd_word[13:7]);
        resp_bytes[2] = data_byte(rd_word[6:0]);
        resp_len      = 2'd3;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      b0_q      <= '0;
      b1_q      <= '0;
      b2_q      <= '0;
      err_count <= '0;
    end else if (rx_fire) begin
      if (is_start)                b0_q <= hdr_t'(bus.rx_data);
      else if (state_q == S_GOT1)  b1_q <= bus.rx_data[6:0];
      else if (state_q == S_GOT2)  b2_q <= bus.rx_data[6:0];
      if (bad_byte && err_count != 8'hFF) err_count <= err_count + 8'd1;
    end
  end

  // NOTE: both banks are reset (not left undefined) because the generators run
  // from the active bank straight out of reset and must start at known phases.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < OUTPUTS; i++) begin
        shadow_q[i] <= OFFSET_W'(i * INIT_STEP);
        active_q[i] <= OFFSET_W'(i * INIT_STEP);
      end
      reload_q <= 1'b0;
    end else begin
      reload_q <= exec && (b0_q.op == OP_COMMIT);
      if (exec && b0_q.op == OP_SET && !ch_bad) shadow_q[ch_idx] <= OFFSET_W'(d_word);
      if (exec && b0_q.op == OP_COMMIT)         active_q <= shadow_q;
    end
  end

  always_comb begin
    offsets = '0;
    for (int j = 0; j < OUTPUTS; j++) offsets[OFFSET_W*j +: OFFSET_W] = active_q[j];
  end

  assign reload_n = !(rst || reload_q);

  resp_serializer u_ser (
    .clk        (clk),
    .rst        (rst),
    .load       (exec),
    .load_bytes (resp_bytes),
    .load_len   (resp_len),
    .tx_data    (bus.tx_data),
    .tx_valid   (bus.tx_valid),
    .tx_ready   (bus.tx_ready),
    .done       (ser_done)
  );

endmodule

// File: tb/tb_phase_cmd_ctrl.sv
// Self-checking bench for phase_cmd_ctrl: directed frames plus a randomized byte stream,
// checked against a frame-queue reference model of the command protocol.
module tb_phase_cmd_ctrl;

  localparam int OUTPUTS   = 16;
  localparam int OFFSET_W  = 24;
  localparam int INIT_STEP = 10;
  localparam int FLAT_W    = OUTPUTS * OFFSET_W;
  typedef logic [FLAT_W-1:0] flat_t;

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  flat_t               offsets;
  logic                reload_n;
  logic [7:0]          err_count;

  phase_cmd_ctrl_if bus ();

  phase_cmd_ctrl #(
    .OUTPUTS   (OUTPUTS),
    .OFFSET_W  (OFFSET_W),
    .INIT_STEP (INIT_STEP)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .offsets   (offsets),
    .reload_n  (reload_n),
    .err_count (err_count)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input flat_t got, input flat_t exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  int unsigned m_shadow [OUTPUTS];
  int unsigned m_active [OUTPUTS];
  logic [7:0]  frame_q [$];
  logic [7:0]  exp_tx  [$];
  int          m_err     = 0;
  int          m_commits = 0;
  int          exec_edge = 0;
  int          cyc       = 0;
  int          tx_mode   = 0;   // 0 random ready, 1 held low, 2 held high

  always @(posedge clk) cyc++;

  task automatic model_reset();
    frame_q.delete();
    exp_tx.delete();
    m_err = 0;
    for (int j = 0; j < OUTPUTS; j++) begin
      m_shadow[j] = j * INIT_STEP;
      m_active[j] = j * INIT_STEP;
    end
  endtask

  task automatic model_error();
    if (m_err < 255) m_err++;
  endtask

  task automatic model_exec();
    logic [7:0]  b0, b1, b2;
    int          op, ch;
    int unsigned d, rd;
    b0 = frame_q[0];
    b1 = frame_q[1];
    b2 = frame_q[2];
    op = int'(b0[6:5]);
    ch = int'(b0[4:0]);
    d  = int'(b1[6:0]) * 128 + int'(b2[6:0]);
    exec_edge = cyc + 1;
    case (op)
      0: if (ch >= OUTPUTS) exp_tx.push_back(8'hFF);
         else begin m_shadow[ch] = d; exp_tx.push_back(b0); end
      1: begin
           for (int j = 0; j < OUTPUTS; j++) m_active[j] = m_shadow[j];
           m_commits++;
           exp_tx.push_back(b0);
         end
      2: if (ch >= OUTPUTS) exp_tx.push_back(8'hFF);
         else begin
           rd = m_shadow[ch] % 16384;
           exp_tx.push_back(b0);
           exp_tx.push_back(8'(rd / 128));
           exp_tx.push_back(8'(rd % 128));
         end
      default: exp_tx.push_back(b0);
    endcase
  endtask

  task automatic model_byte(input logic [7:0] b);
    if (b[7]) begin
      if (frame_q.size() != 0) model_error();
      frame_q.delete();
      frame_q.push_back(b);
    end else if (frame_q.size() == 0) begin
      model_error();
    end else begin
      frame_q.push_back(b);
      if (frame_q.size() == 3) begin
        model_exec();
        frame_q.delete();
      end
    end
  endtask

  function automatic flat_t exp_flat();
    flat_t f = '0;
    for (int j = 0; j < OUTPUTS; j++) f[OFFSET_W*j +: OFFSET_W] = OFFSET_W'(m_active[j]);
    return f;
  endfunction

  function automatic logic [OFFSET_W-1:0] ch_of(input int j);
    return offsets[OFFSET_W*j +: OFFSET_W];
  endfunction

  // ---------------- tx ready driver ----------------
  initial begin
    bus.tx_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (tx_mode)
        1:       bus.tx_ready = 1'b0;
        2:       bus.tx_ready = 1'b1;
        default: bus.tx_ready = ($urandom_range(0, 9) < 7);
      endcase
    end
  end

  // ---------------- output monitor ----------------
  logic       prev_txv = 1'b0, prev_txr = 1'b0, prev_rst = 1'b1, prev_reload_n = 1'b0;
  logic [7:0] prev_txd = 8'h00;
  flat_t      prev_offs = '0;
  int         strobes = 0;

  always @(negedge clk) begin
    if (!rst) begin
      if (bus.tx_valid && bus.tx_ready) begin
        if (exp_tx.size() == 0) check("tx_unexpected", flat_t'(bus.tx_data), flat_t'(9'h100));
        else                    check("tx_byte", flat_t'(bus.tx_data), flat_t'(exp_tx.pop_front()));
      end
      if (!prev_rst && prev_txv && !prev_txr) begin
        check("tx_hold_valid", flat_t'(bus.tx_valid), 1);
        check("tx_hold_data", flat_t'(bus.tx_data), flat_t'(prev_txd));
      end
      if (bus.tx_valid && !prev_txv) check("tx_latency", flat_t'(cyc - exec_edge), 1);
      if (bus.tx_valid) check("rx_ready_busy", flat_t'(bus.rx_ready), 0);
      if (!reload_n) begin
        strobes++;
        check("reload_single", flat_t'(prev_reload_n), 1);
        check("reload_latency", flat_t'(cyc - exec_edge), 1);
        check("reload_offsets", offsets, exp_flat());
      end
      if (!prev_rst && offsets !== prev_offs) check("offs_change_no_reload", flat_t'(reload_n), 0);
    end
    prev_txv      = bus.tx_valid;
    prev_txr      = bus.tx_ready;
    prev_txd      = bus.tx_data;
    prev_rst      = rst;
    prev_reload_n = reload_n;
    prev_offs     = offsets;
  end

  // ---------------- stimulus helpers ----------------
  task automatic align();
    if ($time % 10 != 6) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input bit gaps);
    int budget = 0;
    align();
    if (gaps) repeat ($urandom_range(0, 2)) begin
      @(posedge clk);
      #1;
    end
    bus.rx_data  = b;
    bus.rx_valid = 1'b1;
    forever begin
      @(negedge clk);
      if (bus.rx_ready) break;
      budget++;
      if (budget > 500) begin
        check("rx_accept_timeout", 0, 1);
        bus.rx_valid = 1'b0;
        return;
      end
    end
    model_byte(b);
    @(posedge clk);
    #1;
    bus.rx_valid = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2);
    send_byte(b0, 1'b0);
    send_byte(b1, 1'b0);
    send_byte(b2, 1'b0);
  endtask

  task automatic drain();
    int budget = 0;
    @(negedge clk);
    while ((exp_tx.size() != 0 || bus.tx_valid) && budget < 2000) begin
      @(negedge clk);
      budget++;
    end
    check("drain_pending", flat_t'(exp_tx.size()), 0);
  endtask

  initial begin
    #800000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  initial begin
    int          s0;
    logic [1:0]  op2;
    logic [4:0]  ch5;
    logic [13:0] d;
    logic [7:0]  b0;

    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'h00;
    model_reset();

    // Reset and idle
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_reload_n", flat_t'(reload_n), 0);
    check("rst_rx_ready", flat_t'(bus.rx_ready), 0);
    check("rst_tx_valid", flat_t'(bus.tx_valid), 0);
    check("rst_tx_data", flat_t'(bus.tx_data), 0);
    check("rst_err", flat_t'(err_count), 0);
    check("rst_offsets", offsets, exp_flat());
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("post_rst_reload_n", flat_t'(reload_n), 1);
    check("post_rst_rx_ready", flat_t'(bus.rx_ready), 1);
    repeat (4) @(negedge clk);
    check("idle_ch5", flat_t'(ch_of(5)), 50);
    check("idle_ch15", flat_t'(ch_of(15)), 150);

    // SET ch3, READ before commit, then COMMIT
    send_frame(8'h83, 8'h24, 8'h34);
    drain();
    check("set_active_ch3", flat_t'(ch_of(3)), 30);
    send_frame(8'hC3, 8'h00, 8'h00);
    drain();
    check("read_active_ch3", flat_t'(ch_of(3)), 30);
    s0 = strobes;
    send_frame(8'hA0, 8'h00, 8'h00);
    drain();
    check("commit_ch3", flat_t'(ch_of(3)), 'h1234);
    check("commit_one_strobe", flat_t'(strobes - s0), 1);
    s0 = strobes;
    send_frame(8'hA0, 8'h00, 8'h00);
    send_frame(8'hA7, 8'h11, 8'h22);
    drain();
    check("b2b_commit_strobes", flat_t'(strobes - s0), 2);

    // Out-of-range channels, edge channel, PING
    send_frame(8'h94, 8'h7F, 8'h7F);
    send_frame(8'hD4, 8'h00, 8'h00);
    send_frame(8'h8F, 8'h7F, 8'h7F);
    send_frame(8'hE5, 8'h00, 8'h00);
    send_frame(8'hA0, 8'h00, 8'h00);
    drain();
    check("nak_bank", offsets, exp_flat());
    check("ch15_max", flat_t'(ch_of(15)), 'h3FFF);

    // Framing errors and resync
    send_byte(8'h05, 1'b0);
    send_byte(8'h83, 1'b0);
    send_byte(8'h80, 1'b0);
    send_byte(8'h01, 1'b0);
    send_byte(8'h02, 1'b0);
    drain();
    check("frame_err", flat_t'(err_count), 2);
    send_frame(8'hA0, 8'h00, 8'h00);
    drain();
    check("resync_ch0", flat_t'(ch_of(0)), 'h82);

    // Stalled READ reply, then reset mid-reply
    tx_mode = 1;
    send_frame(8'hC3, 8'h00, 8'h00);
    repeat (20) @(negedge clk);
    check("stall_tx_valid", flat_t'(bus.tx_valid), 1);
    check("stall_tx_data", flat_t'(bus.tx_data), 'hC3);
    check("stall_rx_ready", flat_t'(bus.rx_ready), 0);
    @(posedge clk);
    #1 rst = 1'b1;
    model_reset();
    @(negedge clk);
    check("midrst_tx_valid", flat_t'(bus.tx_valid), 0);
    @(posedge clk);
    #1 rst = 1'b0;
    tx_mode = 0;
    @(negedge clk);
    check("after_rst_tx_valid", flat_t'(bus.tx_valid), 0);
    check("after_rst_offsets", offsets, exp_flat());
    check("after_rst_ch3", flat_t'(ch_of(3)), 30);
    check("after_rst_err", flat_t'(err_count), 0);

    // Randomized frames with occasional stray and restart bytes
    for (int f = 0; f < 300; f++) begin
      case ($urandom_range(0, 5))
        0, 1, 2: op2 = 2'd0;
        3:       op2 = 2'd1;
        4:       op2 = 2'd2;
        default: op2 = 2'd3;
      endcase
      ch5 = 5'($urandom_range(0, 19));
      d   = 14'($urandom);
      b0  = {1'b1, op2, ch5};
      if ($urandom_range(0, 24) == 0) send_byte(8'($urandom_range(0, 127)), 1'b1);
      send_byte(b0, 1'b1);
      if ($urandom_range(0, 24) == 0) send_byte(8'($urandom_range(128, 255)), 1'b1);
      send_byte({1'b0, d[13:7]}, 1'b1);
      send_byte({1'b0, d[6:0]}, 1'b1);
    end
    for (int j = 0; j < OUTPUTS; j++) send_frame(8'hC0 | 8'(j), 8'h00, 8'h00);
    drain();
    check("rand_offsets", offsets, exp_flat());
    check("rand_err", flat_t'(err_count), flat_t'(m_err));

    // Error counter saturation
    for (int k = 0; k < 300; k++) send_byte(8'(k % 128), 1'b0);
    drain();
    check("err_saturate", flat_t'(err_count), 255);
    check("err_model", flat_t'(err_count), flat_t'(m_err));
    check("strobe_total", flat_t'(strobes), flat_t'(m_commits));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
